csa_resolver: RTL and testbench



---
 rtl/csa_pkg.sv | 28 ++
 rtl/csa_chunk_add.sv | 22 ++
 rtl/csa_resolver.sv | 161 ++++++++++++++++
 tb/tb_csa_resolver.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// ---------------------------------------------------------------------------
// csa_pkg
// Shared types and sizing helpers for the carry-save resolver.
//   csa_state_t  : FSM encoding (IDLE, RUN, DONE)
//   csa_nchunks  : number of CW-bit chunks needed to cover DW+2 result bits
//   csa_pw       : padded operand width (whole number of chunks)
// ---------------------------------------------------------------------------
package csa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } csa_state_t;

  // ceil((dw+2)/cw): the sum of a DW-bit vector and a weight-2 DW-bit vector
  // needs DW+2 bits.
  function automatic int csa_nchunks(input int dw, input int cw);
    return (dw + 2 + cw - 1) / cw;
  endfunction

  // Operands are zero-padded to a whole number of chunks so every chunk
  // slice is in range.
  function automatic int csa_pw(input int dw, input int cw);
    return csa_nchunks(dw, cw) * cw;
  endfunction

endpackage

// File: rtl/csa_chunk_add.sv
// ---------------------------------------------------------------------------
// csa_chunk_add
// Combinational CW-bit ripple adder slice with carry in/out.
// Ports:
//   a, b  : CW-bit addends
//   cin   : carry in from the previous chunk
//   sum   : CW-bit sum
//   cout  : carry out to the next chunk
// ---------------------------------------------------------------------------
module csa_chunk_add #(
  parameter int CW = 8
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] sum,
  output logic          cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};

endmodule

// File: rtl/csa_resolver.sv
// ---------------------------------------------------------------------------
// csa_resolver
// Sequential carry-propagate stage: turns a carry-save pair (sum vector s,
// carry vector c of weight 2) into the binary value s + 2*c, resolving CW
// bits per clock with a single chunk adder.
//
// Ports:
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   in_valid   : input pair valid
//   in_ready   : high in IDLE only
//   in_s       : DW-bit sum vector (weight 1)
//   in_c       : DW-bit carry vector (bit i worth 2^(i+1))
//   out_valid  : result valid (DONE state)
//   out_ready  : downstream accepts result
//   out_res    : DW+2-bit exact unsigned result, stable while out_valid
//   busy       : high while chunks are being resolved (RUN state)
//
// Build option:
//   CSA_RESOLVER_EARLY_EXIT_EN - when defined, RUN ends as soon as the carry
//   out of the current chunk is zero and all higher operand bits are zero.
//   When undefined, latency is always NCH edges.
// ---------------------------------------------------------------------------
module csa_resolver
  import csa_pkg::*;
#(
  parameter int DW = 32,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_s,
  input  logic [DW-1:0] in_c,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW+1:0] out_res,
  output logic          busy
);

  localparam int NCH = csa_nchunks(DW, CW);
  localparam int PW  = csa_pw(DW, CW);
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int RW  = DW + 2;

  csa_state_t    state_reg, state_next;
  logic [PW-1:0] op_a_reg, op_b_reg;
  logic [KW-1:0] k_reg;
  logic          carry_reg;
  logic [RW-1:0] res_reg;

  logic [CW-1:0] a_chunks [NCH];
  logic [CW-1:0] b_chunks [NCH];
  logic [CW-1:0] chunk_sum;
  logic          chunk_cout;
  logic          accept;
  logic          last_chunk;
  logic          early_done;

  // Chunk views of the padded operands, selected by k_reg.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_chunk_view
    assign a_chunks[gi] = op_a_reg[gi*CW +: CW];
    assign b_chunks[gi] = op_b_reg[gi*CW +: CW];
  end

  csa_chunk_add #(.CW(CW)) u_chunk_add (
    .a    (a_chunks[k_reg]),
    .b    (b_chunks[k_reg]),
    .cin  (carry_reg),
    .sum  (chunk_sum),
    .cout (chunk_cout)
  );

  assign accept     = (state_reg == IDLE) && in_valid;
  assign last_chunk = (k_reg == KW'(NCH - 1));

`ifdef CSA_RESOLVER_EARLY_EXIT_EN
  // upper_zero[gi]: every operand bit above chunk gi is zero. The top chunk
  // has nothing above it.
  logic [NCH-1:0] upper_zero;
  for (genvar gi = 0; gi < NCH; gi++) begin : g_upper_zero
    if (gi == NCH - 1) begin : g_top
      assign upper_zero[gi] = 1'b1;
    end else begin : g_mid
      assign upper_zero[gi] = ~|{op_a_reg[PW-1:(gi+1)*CW], op_b_reg[PW-1:(gi+1)*CW]};
    end
  end
  // Higher result chunks were cleared at acceptance, so they are already right.
  assign early_done = ~chunk_cout & upper_zero[k_reg];
`else
  assign early_done = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and outputs
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    busy       = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_chunk || early_done) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operands, chunk index and inter-chunk carry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_reg  <= '0;
      op_b_reg  <= '0;
      k_reg     <= '0;
      carry_reg <= 1'b0;
    end else if (accept) begin
      op_a_reg  <= PW'(in_s);
      op_b_reg  <= PW'({in_c, 1'b0});
      k_reg     <= '0;
      carry_reg <= 1'b0;
    end else if (state_reg == RUN) begin
      carry_reg <= chunk_cout;
      // Hold on the last chunk so the index never wraps.
      if (!last_chunk) k_reg <= k_reg + KW'(1);
    end
  end

  // Result register. Only the DW+2 meaningful bits are stored; chunk bits
  // above that in the top chunk are provably zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_reg <= '0;
    end else if (accept) begin
      res_reg <= '0;
    end else if (state_reg == RUN) begin
      for (int b = 0; b < RW; b++) begin
        if ((b / CW) == int'(k_reg)) res_reg[b] <= chunk_sum[b % CW];
      end
    end
  end

  assign out_res = res_reg;

endmodule

// File: tb/tb_csa_resolver.sv
// ---------------------------------------------------------------------------
// tb_csa_resolver
// Directed checks on an 8-bit/4-bit-chunk instance (latency, stall, reset)
// plus a randomized stream on a 32-bit/8-bit-chunk instance with a queue of
// expected sums.
// ---------------------------------------------------------------------------
module tb_csa_resolver;

`ifdef CSA_RESOLVER_EARLY_EXIT_EN
  localparam int EE = 1;
`else
  localparam int EE = 0;
`endif
  localparam int NRAND = 300;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        v8 = 1'b0, or8 = 1'b0;
  logic [7:0]  s8 = '0, c8 = '0;
  logic        rdy8, ov8, busy8;
  logic [9:0]  res8;

  logic        v32 = 1'b0, or32 = 1'b0;
  logic [31:0] s32 = '0, c32 = '0;
  logic        rdy32, ov32, busy32;
  logic [33:0] res32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csa_resolver #(.DW(8), .CW(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .in_s(s8), .in_c(c8),
    .out_valid(ov8), .out_ready(or8), .out_res(res8), .busy(busy8)
  );

  csa_resolver #(.DW(32), .CW(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32), .in_s(s32), .in_c(c32),
    .out_valid(ov32), .out_ready(or32), .out_res(res32), .busy(busy32)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction on dut8: accept at the next edge, count edges until
  // out_valid, check result, then hand it off.
  task automatic run8(input logic [7:0] s, input logic [7:0] c, input logic [9:0] exp,
                      input int exp_lat, input string tag);
    int lat;
    @(negedge clk);
    chk({tag, " in_ready"}, 64'(rdy8), 64'd1);
    s8 = s; c8 = c; v8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v8 = 1'b0;
    s8 = 8'($urandom);
    c8 = 8'($urandom);
    chk({tag, " busy"}, 64'(busy8), 64'd1);
    lat = 0;
    while (!ov8 && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " res"}, 64'(res8), 64'(exp));
    or8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    or8 = 1'b0;
    chk({tag, " out_valid drop"}, 64'(ov8), 64'd0);
    $display("txn %s: s=%h c=%h res=%h latency=%0d", tag, s, c, exp, lat);
  endtask

  initial begin
    int lat;
    int sent, rcvd, cyc;
    logic acc;
    logic [33:0] q[$];

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst in_ready", 64'(rdy8), 64'd1);
    chk("rst out_valid", 64'(ov8), 64'd0);
    chk("rst busy", 64'(busy8), 64'd0);
    chk("rst out_res", 64'(res8), 64'd0);
    chk("rst in_ready32", 64'(rdy32), 64'd1);
    rst = 1'b0;

    // Directed vectors: 0xFF+2*0xFF=0x2FD, 0, 3+2=5, 1+2=3
    run8(8'hFF, 8'hFF, 10'h2FD, 3, "max");
    run8(8'h00, 8'h00, 10'h000, EE ? 1 : 3, "zero");
    run8(8'h03, 8'h01, 10'h005, EE ? 1 : 3, "small");

    // Stall in DONE: 0x80 + 2*0x40 = 0x100, in_valid pulses ignored
    @(negedge clk);
    s8 = 8'h80; c8 = 8'h40; v8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk("stall latency", 64'(lat), 64'd3);
    for (int i = 0; i < 10; i++) begin
      v8 = 1'b1;
      s8 = 8'($urandom);
      c8 = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk("stall res", 64'(res8), 64'h100);
      chk("stall in_ready", 64'(rdy8), 64'd0);
      chk("stall out_valid", 64'(ov8), 64'd1);
    end
    // Release with in_valid still high: no bypass into a new transaction
    or8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    or8 = 1'b0;
    v8 = 1'b0;
    chk("release out_valid", 64'(ov8), 64'd0);
    chk("release in_ready", 64'(rdy8), 64'd1);
    chk("release busy", 64'(busy8), 64'd0);
    $display("txn stall: s=80 c=40 res=100 held 10 cycles");

    // Reset two edges after accepting 0xAA/0x55
    @(negedge clk);
    s8 = 8'hAA; c8 = 8'h55; v8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v8 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("pre-reset res nonzero", 64'(res8 != 10'd0), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst out_valid", 64'(ov8), 64'd0);
    chk("midrst in_ready", 64'(rdy8), 64'd1);
    chk("midrst out_res", 64'(res8), 64'd0);
    chk("midrst busy", 64'(busy8), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    $display("txn reset: s=aa c=55 aborted");
    run8(8'h01, 8'h01, 10'h003, EE ? 1 : 3, "after_rst");

    // Random stream on the 32-bit instance with random backpressure
    sent = 0; rcvd = 0; cyc = 0; acc = 1'b0;
    while ((sent < NRAND || q.size() > 0) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (acc) begin
        v32 = 1'b0;
        acc = 1'b0;
      end
      if (!v32 && sent < NRAND && $urandom_range(0, 3) != 0) begin
        v32 = 1'b1;
        s32 = $urandom;
        c32 = $urandom;
      end
      or32 = 1'($urandom_range(0, 1));
      #1;
      if (ov32 && or32) begin
        chk("rand expected pending", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          logic [33:0] e;
          e = q.pop_front();
          chk("rand res", 64'(res32), 64'(e));
          $display("txn rand %0d: res=%h expected=%h", rcvd, res32, e);
        end
        rcvd++;
      end
      if (v32 && rdy32) begin
        q.push_back({2'b00, s32} + {1'b0, c32, 1'b0});
        sent++;
        acc = 1'b1;
      end
    end
    @(negedge clk);
    v32 = 1'b0;
    or32 = 1'b0;
    chk("rand finished in time", 64'(cyc < 20000), 64'd1);
    chk("rand count", 64'(rcvd), 64'(NRAND));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
